// File: rtl/cache_req_arbiter.sv
// cache_req_arbiter
//   Two-port round-robin request arbiter and miss sequencer in front of the
//   trace-driven cache model. One transaction is in flight at a time.
//   The winning address goes out on the single lookup port. The requester
//   then receives a hit/miss pulse. A miss response is delayed by MISS_LAT
//   fill-penalty cycles.
//
// Parameters
//   ADDR_W    address width (cache model byte address)
//   MISS_LAT  miss fill penalty in cycles, 1..255
//
// Ports
//   clk_41, rst_41                 clock, synchronous active-high reset
//   reqN_valid_41/reqN_addr_41     request from requester N (held until ready)
//   reqN_ready_41                  request N accepted this cycle (IDLE only)
//   respN_valid_41/respN_hit_41    one-cycle response pulse and hit flag
//   lk_valid_41/lk_addr_41         one-cycle lookup strobe and address
//   lk_resp_valid_41/lk_hit_41     cache lookup result (sampled in WAIT only)
//   busy_41                        high whenever not IDLE
//   hitsN_41/missesN_41            saturating per-requester statistics
//
// Build option
//   CACHE_ARB_STATS_EN  when defined, adds the four statistics counters and
//                       their ports.
module cache_req_arbiter #(
  parameter int ADDR_W   = 31,
  parameter int MISS_LAT = 8
) (
  input  logic              clk_41,
  input  logic              rst_41,
  input  logic              req0_valid_41,
  input  logic [ADDR_W-1:0] req0_addr_41,
  output logic              req0_ready_41,
  output logic              resp0_valid_41,
  output logic              resp0_hit_41,
  input  logic              req1_valid_41,
  input  logic [ADDR_W-1:0] req1_addr_41,
  output logic              req1_ready_41,
  output logic              resp1_valid_41,
  output logic              resp1_hit_41,
  output logic              lk_valid_41,
  output logic [ADDR_W-1:0] lk_addr_41,
  input  logic              lk_resp_valid_41,
  input  logic              lk_hit_41,
  output logic              busy_41
`ifdef CACHE_ARB_STATS_EN
  ,
  output logic [30:0]       hits0_41,
  output logic [30:0]       misses0_41,
  output logic [30:0]       hits1_41,
  output logic [30:0]       misses1_41
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_PENALTY,
    S_RESP
  } state_t;

  state_t            state_q, state_d;
  logic              last_grant_q;
  logic              id_q;
  logic              hit_q;
  logic [7:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;

  logic grant0, grant1, xfer;

  // Tie goes to whichever requester was not granted last.
  assign grant0 = req0_valid_41 & (~req1_valid_41 | last_grant_q);
  assign grant1 = req1_valid_41 & (~req0_valid_41 | ~last_grant_q);

  // Ready is masked by reset so nothing looks accepted in a reset cycle.
  assign req0_ready_41 = (state_q == S_IDLE) & ~rst_41 & grant0;
  assign req1_ready_41 = (state_q == S_IDLE) & ~rst_41 & grant1;
  assign xfer          = req0_ready_41 | req1_ready_41;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (xfer) state_d = S_ISSUE;
      S_ISSUE:   state_d = S_WAIT;
      S_WAIT:    if (lk_resp_valid_41) state_d = lk_hit_41 ? S_RESP : S_PENALTY;
      S_PENALTY: if (cnt_q == 8'd0) state_d = S_RESP;
      S_RESP:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_41) begin
    if (rst_41) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      hit_q        <= 1'b0;
      cnt_q        <= 8'd0;
    end else begin
      state_q <= state_d;
      if (xfer) begin
        id_q         <= req1_ready_41;
        last_grant_q <= req1_ready_41;
      end
      if (state_q == S_WAIT && lk_resp_valid_41) begin
        hit_q <= lk_hit_41;
        cnt_q <= 8'(MISS_LAT - 1);
      end else if (state_q == S_PENALTY && cnt_q != 8'd0) begin
        cnt_q <= cnt_q - 8'd1;
      end
    end
  end

  // Address is data only; it is qualified by the ISSUE state on output.
  always_ff @(posedge clk_41) begin
    if (xfer) addr_q <= req1_ready_41 ? req1_addr_41 : req0_addr_41;
  end

  assign lk_valid_41    = (state_q == S_ISSUE);
  assign lk_addr_41     = lk_valid_41 ? addr_q : '0;
  assign resp0_valid_41 = (state_q == S_RESP) & ~id_q;
  assign resp1_valid_41 = (state_q == S_RESP) & id_q;
  assign resp0_hit_41   = resp0_valid_41 & hit_q;
  assign resp1_hit_41   = resp1_valid_41 & hit_q;
  assign busy_41        = (state_q != S_IDLE);

`ifdef CACHE_ARB_STATS_EN
  function automatic logic [30:0] sat_inc(input logic [30:0] v);
    return (v == '1) ? v : v + 31'd1;
  endfunction

  always_ff @(posedge clk_41) begin
    if (rst_41) begin
      hits0_41   <= '0;
      misses0_41 <= '0;
      hits1_41   <= '0;
      misses1_41 <= '0;
    end else if (state_q == S_RESP) begin
      case ({id_q, hit_q})
        2'b01:   hits0_41   <= sat_inc(hits0_41);
        2'b00:   misses0_41 <= sat_inc(misses0_41);
        2'b11:   hits1_41   <= sat_inc(hits1_41);
        default: misses1_41 <= sat_inc(misses1_41);
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_cache_req_arbiter.sv
module tb_cache_req_arbiter;
  localparam int ADDR_W   = 31;
  localparam int MISS_LAT = 8;

  logic              clk_41 = 1'b0;
  logic              rst_41;
  logic              req0_valid_41, req1_valid_41;
  logic [ADDR_W-1:0] req0_addr_41, req1_addr_41;
  logic              req0_ready_41, req1_ready_41;
  logic              resp0_valid_41, resp0_hit_41, resp1_valid_41, resp1_hit_41;
  logic              lk_valid_41;
  logic [ADDR_W-1:0] lk_addr_41;
  logic              lk_resp_valid_41, lk_hit_41;
  logic              busy_41;
`ifdef CACHE_ARB_STATS_EN
  logic [30:0] hits0_41, misses0_41, hits1_41, misses1_41;
  int m_h0 = 0, m_m0 = 0, m_h1 = 0, m_m1 = 0;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk_41 = ~clk_41;

  cache_req_arbiter #(.ADDR_W(ADDR_W), .MISS_LAT(MISS_LAT)) dut (
    .clk_41(clk_41), .rst_41(rst_41),
    .req0_valid_41(req0_valid_41), .req0_addr_41(req0_addr_41),
    .req0_ready_41(req0_ready_41), .resp0_valid_41(resp0_valid_41),
    .resp0_hit_41(resp0_hit_41),
    .req1_valid_41(req1_valid_41), .req1_addr_41(req1_addr_41),
    .req1_ready_41(req1_ready_41), .resp1_valid_41(resp1_valid_41),
    .resp1_hit_41(resp1_hit_41),
    .lk_valid_41(lk_valid_41), .lk_addr_41(lk_addr_41),
    .lk_resp_valid_41(lk_resp_valid_41), .lk_hit_41(lk_hit_41),
    .busy_41(busy_41)
`ifdef CACHE_ARB_STATS_EN
    , .hits0_41(hits0_41), .misses0_41(misses0_41),
    .hits1_41(hits1_41), .misses1_41(misses1_41)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_41);
    #1;
  endtask

  // One full transaction starting in an IDLE cycle T. The cache answers at
  // T+2+delay; with stray set, a bogus hit is pulsed during ISSUE.
  task automatic run_txn(input bit v0, input bit v1,
                         input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                         input bit hit, input int delay, input bit stray,
                         input bit exp_id);
    logic [ADDR_W-1:0] ea;
    int lat;
    ea = exp_id ? a1 : a0;
    req0_valid_41 = v0; req0_addr_41 = a0;
    req1_valid_41 = v1; req1_addr_41 = a1;
    #1;
    chk("idle_busy", {31'd0, busy_41}, 0);
    chk("ready0", {31'd0, req0_ready_41}, {31'd0, exp_id == 1'b0});
    chk("ready1", {31'd0, req1_ready_41}, {31'd0, exp_id == 1'b1});
    step();  // T+1: ISSUE
    req0_valid_41 = 1'b0; req0_addr_41 = ~a0;
    req1_valid_41 = 1'b0; req1_addr_41 = ~a1;
    if (stray) begin lk_resp_valid_41 = 1'b1; lk_hit_41 = 1'b1; end
    #1;
    chk("lk_valid", {31'd0, lk_valid_41}, 1);
    chk("lk_addr", {1'b0, lk_addr_41}, {1'b0, ea});
    step();  // T+2: WAIT
    lk_resp_valid_41 = 1'b0; lk_hit_41 = 1'b0;
    chk("lk_valid_once", {31'd0, lk_valid_41}, 0);
    for (int d = 0; d < delay; d++) begin
      chk("wait_noresp", {30'd0, resp0_valid_41, resp1_valid_41}, 0);
      chk("wait_busy", {31'd0, busy_41}, 1);
      step();
    end
    lk_resp_valid_41 = 1'b1; lk_hit_41 = hit;
    step();
    lk_resp_valid_41 = 1'b0; lk_hit_41 = 1'b0;
    lat = 1;
    while (!(resp0_valid_41 || resp1_valid_41) && lat < 400) begin
      step();
      lat++;
    end
    chk("resp_latency", lat, hit ? 1 : MISS_LAT + 1);
    chk("resp0_valid", {31'd0, resp0_valid_41}, {31'd0, exp_id == 1'b0});
    chk("resp1_valid", {31'd0, resp1_valid_41}, {31'd0, exp_id == 1'b1});
    chk("resp_hit", {31'd0, exp_id ? resp1_hit_41 : resp0_hit_41}, {31'd0, hit});
`ifdef CACHE_ARB_STATS_EN
    if (exp_id == 1'b0) begin if (hit) m_h0++; else m_m0++; end
    else begin if (hit) m_h1++; else m_m1++; end
`endif
    step();
    chk("after_resp_busy", {31'd0, busy_41}, 0);
    chk("after_resp_pulse", {30'd0, resp0_valid_41, resp1_valid_41}, 0);
  endtask

  typedef struct {
    bit              v0;
    bit              v1;
    logic [ADDR_W-1:0] a0;
    logic [ADDR_W-1:0] a1;
    bit              hit;
    int              delay;
    bit              stray;
    bit              exp_id;
  } vec_t;

  vec_t tbl[9];

  initial begin
    // tie sequence after reset, then single hit/miss and mixed patterns
    tbl[0] = '{1, 1, 31'h100,       31'h200, 1, 0, 0, 0};
    tbl[1] = '{1, 1, 31'h104,       31'h204, 1, 0, 0, 1};
    tbl[2] = '{1, 1, 31'h108,       31'h208, 1, 0, 0, 0};
    tbl[3] = '{1, 1, 31'h10C,       31'h20C, 1, 0, 0, 1};
    tbl[4] = '{1, 0, 31'h100,       31'h0,   1, 0, 0, 0};
    tbl[5] = '{0, 1, 31'h0,         31'h300, 0, 0, 0, 1};
    tbl[6] = '{1, 1, 31'h7FFFFFFF,  31'h0,   0, 3, 0, 0};
    tbl[7] = '{1, 1, 31'h55555555,  31'h2AAAAAAA, 1, 2, 0, 1};
    tbl[8] = '{0, 1, 31'h0,         31'h440, 1, 0, 0, 1};

    rst_41 = 1'b1;
    req0_valid_41 = 1'b0; req1_valid_41 = 1'b0;
    req0_addr_41 = '0; req1_addr_41 = '0;
    lk_resp_valid_41 = 1'b0; lk_hit_41 = 1'b0;
    step();
    step();
    chk("rst_busy", {31'd0, busy_41}, 0);
    chk("rst_lk_valid", {31'd0, lk_valid_41}, 0);
    chk("rst_lk_addr", {1'b0, lk_addr_41}, 0);
    chk("rst_resp", {28'd0, resp0_valid_41, resp0_hit_41, resp1_valid_41, resp1_hit_41}, 0);
    chk("rst_ready", {30'd0, req0_ready_41, req1_ready_41}, 0);
`ifdef CACHE_ARB_STATS_EN
    chk("rst_hits0", {1'b0, hits0_41}, 0);
    chk("rst_misses1", {1'b0, misses1_41}, 0);
`endif
    rst_41 = 1'b0;

    for (int i = 0; i < 9; i++)
      run_txn(tbl[i].v0, tbl[i].v1, tbl[i].a0, tbl[i].a1, tbl[i].hit,
              tbl[i].delay, tbl[i].stray, tbl[i].exp_id);

`ifdef CACHE_ARB_STATS_EN
    chk("hits0", {1'b0, hits0_41}, m_h0);
    chk("misses0", {1'b0, misses0_41}, m_m0);
    chk("hits1", {1'b0, hits1_41}, m_h1);
    chk("misses1", {1'b0, misses1_41}, m_m1);
`endif

    // Stray response in IDLE must be ignored.
    lk_resp_valid_41 = 1'b1; lk_hit_41 = 1'b1;
    step();
    lk_resp_valid_41 = 1'b0; lk_hit_41 = 1'b0;
    chk("stray_idle_busy", {31'd0, busy_41}, 0);
    chk("stray_idle_resp", {30'd0, resp0_valid_41, resp1_valid_41}, 0);
    step();
    chk("stray_idle_resp2", {30'd0, resp0_valid_41, resp1_valid_41}, 0);

    // Stray response in ISSUE, real miss two cycles into WAIT.
    run_txn(1, 0, 31'h600, 31'h0, 0, 2, 1, 0);

    // Reset during PENALTY: transaction discarded, req0 wins right after.
    req0_valid_41 = 1'b1; req0_addr_41 = 31'h40;
    #1;
    chk("mid_ready0", {31'd0, req0_ready_41}, 1);
    step();  // ISSUE
    req0_valid_41 = 1'b0;
    step();  // WAIT
    lk_resp_valid_41 = 1'b1; lk_hit_41 = 1'b0;
    step();  // PENALTY 1
    lk_resp_valid_41 = 1'b0;
    chk("mid_penalty_busy", {31'd0, busy_41}, 1);
    step();  // PENALTY 2
    rst_41 = 1'b1;
    #1;
    chk("rst_cycle_noready", {31'd0, req0_ready_41}, 0);
    step();
    rst_41 = 1'b0;
    chk("mid_rst_busy", {31'd0, busy_41}, 0);
    chk("mid_rst_resp", {30'd0, resp0_valid_41, resp1_valid_41}, 0);
`ifdef CACHE_ARB_STATS_EN
    m_h0 = 0; m_m0 = 0; m_h1 = 0; m_m1 = 0;
    chk("mid_rst_misses0", {1'b0, misses0_41}, 0);
`endif
    // last_grant back to 1, so req0 wins this tie.
    run_txn(1, 1, 31'h80, 31'h90, 1, 0, 0, 0);

    // Idle stretch: no late pulse from the discarded miss.
    for (int k = 0; k < MISS_LAT + 2; k++) begin
      step();
      chk("post_rst_quiet", {30'd0, resp0_valid_41, resp1_valid_41}, 0);
    end

    // MISS_LAT-spec statistics pattern: req0 3 hits 1 miss, req1 2 misses.
    run_txn(1, 0, 31'h10, 31'h0, 1, 0, 0, 0);
    run_txn(1, 0, 31'h14, 31'h0, 0, 0, 0, 0);
    run_txn(0, 1, 31'h0, 31'h20, 0, 1, 0, 1);
    run_txn(1, 0, 31'h18, 31'h0, 1, 0, 0, 0);
    run_txn(0, 1, 31'h0, 31'h24, 0, 0, 0, 1);
`ifdef CACHE_ARB_STATS_EN
    chk("stat_hits0", {1'b0, hits0_41}, m_h0);
    chk("stat_misses0", {1'b0, misses0_41}, m_m0);
    chk("stat_hits1", {1'b0, hits1_41}, m_h1);
    chk("stat_misses1", {1'b0, misses1_41}, m_m1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_req_arbiter.md
# cache_req_arbiter

Two-port request arbiter and miss sequencer in front of the trace-driven cache model. It accepts address requests from two requesters (instruction and data trace streams) and grants one at a time, round-robin. It issues the winning address to the single cache lookup port, then returns a hit/miss response to the winner. On a miss, the response is held off by a fixed fill penalty of `MISS_LAT` cycles.

## Interface
- `ADDR_W`, 31: address width. Matches the cache model's byte-address input.
- `MISS_LAT`, 8: miss fill penalty in cycles. Legal range is 1..255.
- `clk_41` input 1: clock; all state changes on the rising edge.
- `rst_41` input 1: synchronous, active-high reset.
- `req0_valid_41` input 1: requester 0 has a request.
- `req0_addr_41` input `ADDR_W`: requester 0 address.
- `req0_ready_41` output 1: requester 0 request accepted this cycle.
- `resp0_valid_41` output 1: one-cycle response pulse to requester 0.
- `resp0_hit_41` output 1: hit flag; meaningful only with `resp0_valid_41`.
- `req1_valid_41`, `req1_addr_41`, `req1_ready_41`, `resp1_valid_41`, `resp1_hit_41`: same definitions for requester 1.
- `lk_valid_41` output 1: one-cycle lookup strobe to the cache.
- `lk_addr_41` output `ADDR_W`: lookup address, valid with `lk_valid_41`.
- `lk_resp_valid_41` input 1: cache lookup result valid.
- `lk_hit_41` input 1: cache hit flag, sampled with `lk_resp_valid_41`.
- `busy_41` output 1: high in any state other than IDLE.
- `hits0_41`, `misses0_41`, `hits1_41`, `misses1_41` output 31 each: per-requester statistics. Present only with `CACHE_ARB_STATS_EN`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, PENALTY, RESP.
- IDLE:
  - `reqN_ready_41` is combinational: high only for the arbitration winner.
  - A request transfers when valid and ready are both high.
  - On transfer: latch the address and requester id, then go to ISSUE.
- Arbitration:
  - If only one requester is valid, it wins.
  - If both are valid, the requester not granted last wins.
  - `last_grant` resets to 1, so req0 wins the first tie.
- ISSUE: `lk_valid_41`=1 for exactly one cycle, with `lk_addr_41` set to the latched address; go to WAIT.
- WAIT:
  - Waits indefinitely for `lk_resp_valid_41`.
  - Hit: go to RESP with hit=1.
  - Miss: load the penalty counter with `MISS_LAT`-1 and go to PENALTY.
- PENALTY: the counter decrements each cycle; when it is 0, go to RESP with hit=0.
- RESP: the latched requester's `respN_valid_41`=1 for one cycle with `respN_hit_41`; go to IDLE.
- `lk_resp_valid_41` is ignored in every state except WAIT.
- The requester must hold valid and address stable until ready. The block never drops an accepted request except on reset.
- Only one transaction is in flight at a time; there is no pipelining.

## Timing
- Reset values:
  - All outputs 0; `lk_addr_41` = 0.
  - State IDLE; `last_grant` = 1.
  - Statistics counters 0.
- Request accepted at cycle T: `lk_valid_41` at T+1.
- Cache responds at cycle R ≥ T+2:
  - Hit: response at R+1.
  - Miss: PENALTY occupies R+1..R+`MISS_LAT`; response at R+`MISS_LAT`+1.
- The earliest next acceptance is the cycle after RESP. Minimum hit turnaround is accept at T, next accept at T+4.
- Reset asserted in any state: next cycle is IDLE, the in-flight transaction is discarded, and no response pulse is produced. Reset has priority over all other inputs.
- `MISS_LAT`=1: PENALTY lasts one cycle.

## Configuration
- `CACHE_ARB_STATS_EN` defined:
  - Four 31-bit counters are instantiated.
  - In RESP, the winner's hit or miss counter increments by 1.
  - Counters saturate at 2^31-1 and clear on reset.
- `CACHE_ARB_STATS_EN` undefined: the counters and their ports are absent, and functional behaviour is otherwise identical.

## Test plan
- Single hit:
  - Stimulus: req0 with addr 0x100 accepted at T; cache responds hit at T+2.
  - Required: `lk_addr_41`=0x100 at T+1; `resp0_valid_41`=1 and `resp0_hit_41`=1 at T+3; `busy_41` low at T+4.
- Single miss, `MISS_LAT`=8:
  - Stimulus: req1 accepted at T; miss response at T+2.
  - Required: `resp1_valid_41`=1 and `resp1_hit_41`=0 at T+11 only.
- Tie after reset:
  - Stimulus: both requesters valid continuously after reset, cache always hits.
  - Required: grants go req0, req1, req0, req1; each responds to its own port.
- Reset mid-operation:
  - Stimulus: assert `rst_41` for one cycle during PENALTY.
  - Required: no response pulse; state IDLE; a new req0 is accepted on the cycle after reset deasserts.
- Stray response:
  - Stimulus: pulse `lk_resp_valid_41` while in IDLE and in ISSUE.
  - Required: no state change and no response.
- Statistics (`CACHE_ARB_STATS_EN` defined):
  - Stimulus: req0 three hits and one miss; req1 two misses.
  - Required: `hits0_41`=3, `misses0_41`=1, `hits1_41`=0, `misses1_41`=2.
